sim_radio_tx_check: RTL and testbench

Simulation-only consumer and checker for the radio TX interface of the RFNoC radio block. It drives a randomized `radio_tx_stb` consume strobe, samples `radio_tx_data` on every strobe, and checks each channel against an incrementing sample sequence. It also captures the radio time of the first consumed word and counts words and mismatches for the testbench. It sits on the radio side of `rfnoc_block_radio` in block testbenches and mirrors the RX-side pattern generator.

---
 rtl/sim_radio_pkg.sv | 21 ++
 rtl/sim_radio_tx_if.sv | 30 +++
 rtl/sim_radio_chan_check.sv | 87 ++++++++
 rtl/sim_radio_tx_check.sv | 50 +++++
 tb/tb_sim_radio_tx_check.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sim_radio_pkg.sv
// Shared types and seeding helper for the simulated radio TX checker
// and the stimulus generators that feed it.
package sim_radio_pkg;

  typedef logic [31:0] sample_t;
  typedef logic [63:0] radio_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CHECK
  } chk_state_t;

  // Channel n starts at n * 2^samp_w / num_ch, so every channel's sequence is distinct.
  function automatic sample_t radio_init(int ch, int num_ch, int samp_w);
    logic [63:0] full;
    full = 64'(ch) << samp_w;
    return sample_t'(full / 64'(num_ch));
  endfunction

endpackage

// File: rtl/sim_radio_tx_if.sv
// Radio TX side of the radio block: sample words, running flags, timestamp
// and the consume strobe returned by the radio model.
interface sim_radio_tx_if
  import sim_radio_pkg::*;
#(
  parameter int NSPC         = 1,
  parameter int SAMP_W       = 32,
  parameter int NUM_CHANNELS = 1
) ();

  logic [NUM_CHANNELS*SAMP_W*NSPC-1:0] radio_tx_data;
  logic [NUM_CHANNELS-1:0]             radio_tx_running;
  radio_t                              radio_time;
  logic [NUM_CHANNELS-1:0]             radio_tx_stb;

  modport master (
    output radio_tx_data,
    output radio_tx_running,
    output radio_time,
    input  radio_tx_stb
  );

  modport slave (
    input  radio_tx_data,
    input  radio_tx_running,
    input  radio_time,
    output radio_tx_stb
  );

endinterface

// File: rtl/sim_radio_chan_check.sv
// Per-channel checker: IDLE/SYNC/CHECK tracking of an incrementing sample sequence.
// Latency: counters, first_time and locked reflect a consumed word one edge later.
// Backpressure: none; a word is taken whenever consume is high.
module sim_radio_chan_check
  import sim_radio_pkg::*;
#(
  parameter int NSPC        = 1,
  parameter int SAMP_W      = 32,
  parameter int MAX_ERR_LOG = 1,
  parameter int CHAN        = 0
) (
  input  logic                   radio_clk,
  input  logic                   radio_rst,
  input  logic                   running,
  input  logic                   consume,
  input  logic [NSPC*SAMP_W-1:0] rx_word,
  input  radio_t                 radio_time,
  output logic [31:0]            word_count,
  output logic [31:0]            err_count,
  output radio_t                 first_time,
  output logic                   locked
);

  localparam int WORD_W = NSPC * SAMP_W;

  chk_state_t        state, state_nxt;
  logic [WORD_W-1:0] exp_word, exp_nxt;
  logic [31:0]       intra_errs, err_inc, err_nxt, log_cnt;
  logic [32:0]       err_sum;
  logic              word_bad;

  always_comb begin
    exp_nxt    = '0;
    intra_errs = '0;
    word_bad   = 1'b0;
    for (int s = 0; s < NSPC; s++) begin
      exp_nxt[s*SAMP_W +: SAMP_W] = rx_word[s*SAMP_W +: SAMP_W] + SAMP_W'(NSPC);
      if (rx_word[s*SAMP_W +: SAMP_W] != rx_word[SAMP_W-1:0] + SAMP_W'(s))
        intra_errs = intra_errs + 32'd1;
      if (rx_word[s*SAMP_W +: SAMP_W] != exp_word[s*SAMP_W +: SAMP_W])
        word_bad = 1'b1;
    end

    state_nxt = state;
    err_inc   = '0;
    case (state)
      IDLE:    if (running) state_nxt = SYNC;
      SYNC:    if (consume) begin
                 state_nxt = CHECK;
                 err_inc   = intra_errs;
               end
      CHECK:   if (consume) err_inc = {31'd0, word_bad};
      default: state_nxt = IDLE;
    endcase
    if (!running) state_nxt = IDLE;

    // Saturating accumulate; a whole word in CHECK contributes at most one error.
    err_sum = {1'b0, err_count} + {1'b0, err_inc};
    err_nxt = err_sum[32] ? '1 : err_sum[31:0];
  end

  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      state      <= IDLE;
      exp_word   <= '0;
      word_count <= '0;
      err_count  <= '0;
      first_time <= '0;
      log_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (consume && state != IDLE) begin
        exp_word   <= exp_nxt;
        word_count <= word_count + 32'd1;
        err_count  <= err_nxt;
        if (state == SYNC) first_time <= radio_time;
        if (err_inc != '0 && log_cnt < 32'(MAX_ERR_LOG)) begin
          log_cnt <= log_cnt + 32'd1;
          $error("sim_radio_chan_check ch%0d: rx %0h expected %0h", CHAN, rx_word, exp_word);
        end
      end
    end
  end

  assign locked = (state == CHECK);

endmodule

// File: rtl/sim_radio_tx_check.sv
// Simulated radio TX consumer: random shared strobe plus one sequence checker per channel.
// Latency: strobe registered; per-channel status reflects a consumed word one edge later.
// Backpressure: the randomized strobe is the only flow control toward the source.
module sim_radio_tx_check
  import sim_radio_pkg::*;
#(
  parameter int NSPC         = 1,
  parameter int SAMP_W       = 32,
  parameter int NUM_CHANNELS = 1,
  parameter int STB_PROB     = 50,
  parameter int MAX_ERR_LOG  = 1
) (
  input  logic                        radio_clk,
  input  logic                        radio_rst,
  sim_radio_tx_if.slave               tx,
  output logic [NUM_CHANNELS*32-1:0]  word_count,
  output logic [NUM_CHANNELS*32-1:0]  err_count,
  output logic [NUM_CHANNELS*64-1:0]  first_time,
  output logic [NUM_CHANNELS-1:0]     locked
);

  localparam int WORD_W = SAMP_W * NSPC;

  // The strobe runs even while not transmitting, modelling a radio that underflows.
  always_ff @(posedge radio_clk) begin
    if (radio_rst) tx.radio_tx_stb <= '0;
    else           tx.radio_tx_stb <= (int'($urandom_range(99)) < STB_PROB) ? '1 : '0;
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    sim_radio_chan_check #(
      .NSPC        (NSPC),
      .SAMP_W      (SAMP_W),
      .MAX_ERR_LOG (MAX_ERR_LOG),
      .CHAN        (ch)
    ) u_chan (
      .radio_clk  (radio_clk),
      .radio_rst  (radio_rst),
      .running    (tx.radio_tx_running[ch]),
      .consume    (tx.radio_tx_stb[ch] & tx.radio_tx_running[ch]),
      .rx_word    (tx.radio_tx_data[ch*WORD_W +: WORD_W]),
      .radio_time (tx.radio_time),
      .word_count (word_count[ch*32 +: 32]),
      .err_count  (err_count[ch*32 +: 32]),
      .first_time (first_time[ch*64 +: 64]),
      .locked     (locked[ch])
    );
  end

endmodule

// File: tb/tb_sim_radio_tx_check.sv
// Bench for sim_radio_tx_check: a 2-channel NSPC=2 instance and a 1-channel 16-bit instance,
// fed by an incrementing source that advances on every strobed, running edge.
module tb_sim_radio_tx_check;
  import sim_radio_pkg::*;

  logic radio_clk = 1'b0;
  logic radio_rst;
  logic [63:0] rtime = '0;
  always #5 radio_clk = ~radio_clk;
  always @(posedge radio_clk) rtime <= rtime + 64'd1;

  sim_radio_tx_if #(.NSPC(2), .SAMP_W(32), .NUM_CHANNELS(2)) a_if ();
  sim_radio_tx_if #(.NSPC(1), .SAMP_W(16), .NUM_CHANNELS(1)) b_if ();
  assign a_if.radio_time = rtime;
  assign b_if.radio_time = rtime;

  logic [63:0]  a_wc, a_ec;
  logic [127:0] a_ft;
  logic [1:0]   a_lk;
  logic [31:0]  b_wc, b_ec;
  logic [63:0]  b_ft;
  logic [0:0]   b_lk;

  sim_radio_tx_check #(.NSPC(2), .SAMP_W(32), .NUM_CHANNELS(2), .STB_PROB(50), .MAX_ERR_LOG(0)) dut_a (
    .radio_clk(radio_clk), .radio_rst(radio_rst), .tx(a_if),
    .word_count(a_wc), .err_count(a_ec), .first_time(a_ft), .locked(a_lk));

  sim_radio_tx_check #(.NSPC(1), .SAMP_W(16), .NUM_CHANNELS(1), .STB_PROB(50), .MAX_ERR_LOG(0)) dut_b (
    .radio_clk(radio_clk), .radio_rst(radio_rst), .tx(b_if),
    .word_count(b_wc), .err_count(b_ec), .first_time(b_ft), .locked(b_lk));

  typedef struct {
    logic [31:0] start;
    int          nwords;
    int          skip;
    int          idle;
    logic [31:0] err0;
  } vec_t;

  vec_t        vecs [4];
  int          total, bad;
  logic        rst_req;
  logic [2:0]  run_req;
  logic [31:0] src [3];
  chk_state_t  ms [3];
  logic [31:0] mw [3];
  logic [63:0] mft [3];
  int          phase_w [3];
  int          skip_at [3];
  logic [63:0] prev_ft;

  function automatic logic [31:0] wc(int k);
    return (k < 2) ? a_wc[k*32 +: 32] : b_wc;
  endfunction
  function automatic logic [31:0] ec(int k);
    return (k < 2) ? a_ec[k*32 +: 32] : b_ec;
  endfunction
  function automatic logic [63:0] ft(int k);
    return (k < 2) ? a_ft[k*64 +: 64] : b_ft;
  endfunction
  function automatic logic lk(int k);
    return (k < 2) ? a_lk[k] : b_lk[0];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_chan(int k, string tag, logic [31:0] exp_err);
    chk({tag, "_lock"},  64'(lk(k)), 64'd1);
    chk({tag, "_words"}, 64'(wc(k)), 64'(mw[k]));
    chk({tag, "_errs"},  64'(ec(k)), 64'(exp_err));
    chk({tag, "_ftime"}, ft(k),      mft[k]);
  endtask

  // Called at a falling edge: drive, predict the coming rising edge, then advance the source.
  task automatic cycle();
    logic [2:0] cons;
    radio_rst             = rst_req;
    a_if.radio_tx_data    = {src[1] + 32'd1, src[1], src[0] + 32'd1, src[0]};
    a_if.radio_tx_running = run_req[1:0];
    b_if.radio_tx_data    = src[2][15:0];
    b_if.radio_tx_running = run_req[2];
    cons = {b_if.radio_tx_stb[0], a_if.radio_tx_stb} & run_req & {3{~rst_req}};
    for (int k = 0; k < 3; k++) begin
      if (rst_req) begin
        ms[k] = IDLE; mw[k] = '0; mft[k] = '0;
      end else if (!run_req[k]) begin
        ms[k] = IDLE;
      end else begin
        case (ms[k])
          IDLE: ms[k] = SYNC;
          SYNC: if (cons[k]) begin
                  mw[k] = mw[k] + 32'd1; mft[k] = rtime; ms[k] = CHECK; phase_w[k]++;
                end
          default: if (cons[k]) begin
                  mw[k] = mw[k] + 32'd1; phase_w[k]++;
                end
        endcase
      end
    end
    @(posedge radio_clk);
    for (int k = 0; k < 3; k++) begin
      if (cons[k]) begin
        int stp;
        stp = (k < 2) ? 2 : 1;
        if (skip_at[k] > 0 && phase_w[k] == skip_at[k]) stp = 2 * stp;
        src[k] = src[k] + 32'(stp);
      end
    end
    @(negedge radio_clk);
  endtask

  task automatic run_until(int k, int n);
    int budget;
    budget = 20 * n + 100;
    while (phase_w[k] < n && budget > 0) begin
      cycle();
      budget--;
    end
    if (phase_w[k] < n) begin
      total++; bad++;
      $display("FAIL timeout ch%0d: got %0d words want %0d", k, phase_w[k], n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_req = 1'b1; run_req = '0; radio_rst = 1'b1;
    a_if.radio_tx_data = '0; a_if.radio_tx_running = '0;
    b_if.radio_tx_data = '0; b_if.radio_tx_running = '0;
    for (int k = 0; k < 3; k++) begin
      src[k] = '0; ms[k] = IDLE; mw[k] = '0; mft[k] = '0; phase_w[k] = 0; skip_at[k] = 0;
    end
    //           start          words skip idle cum. ch0 errors
    vecs[0] = '{32'h0000_0010, 1000,   0,   2, 32'd0};
    vecs[1] = '{32'h0000_0010,  200, 100,   3, 32'd1};
    vecs[2] = '{32'h0000_1234,   50,   0,  20, 32'd1};
    vecs[3] = '{32'hFFFF_FFFC,   20,   5,   2, 32'd2};

    @(negedge radio_clk);
    repeat (3) cycle();
    rst_req = 1'b0;
    chk("rst_stb_a", 64'(a_if.radio_tx_stb), 64'd0);
    chk("rst_stb_b", 64'(b_if.radio_tx_stb), 64'd0);
    chk("rst_wc_a",  a_wc, 64'd0);
    chk("rst_ec_a",  a_ec, 64'd0);
    chk("rst_ft_a0", a_ft[63:0], 64'd0);
    chk("rst_lk_a",  64'(a_lk), 64'd0);
    chk("rst_wc_b",  64'(b_wc), 64'd0);
    chk("rst_lk_b",  64'(b_lk), 64'd0);

    for (int i = 0; i < 4; i++) begin
      run_req[1:0] = 2'b00;
      repeat (vecs[i].idle) cycle();
      if (i == 0) while (rtime < 64'd500) cycle();
      prev_ft = ft(0);
      src[0] = vecs[i].start;
      src[1] = vecs[i].start + radio_init(1, 2, 32);
      phase_w[0] = 0; phase_w[1] = 0;
      skip_at[0] = vecs[i].skip; skip_at[1] = 0;
      run_req[1:0] = 2'b11;
      run_until(0, vecs[i].nwords);
      chk_chan(0, $sformatf("v%0d_c0", i), vecs[i].err0);
      chk_chan(1, $sformatf("v%0d_c1", i), 32'd0);
      if (i == 0) begin
        chk("v0_wc_1000", 64'(wc(0)), 64'd1000);
        chk("v0_ft_ge_500", 64'(ft(0) >= 64'd500), 64'd1);
      end else begin
        chk($sformatf("v%0d_ft_moved", i), 64'(ft(0) > prev_ft), 64'd1);
      end
    end

    // 16-bit channel crossing 0xFFFF -> 0x0000.
    run_req = 3'b000;
    repeat (2) cycle();
    src[2] = 32'h0000_FFFE; phase_w[2] = 0; skip_at[2] = 0;
    run_req[2] = 1'b1;
    run_until(2, 40);
    chk_chan(2, "wrap", 32'd0);
    chk("wrap_wc", 64'(wc(2)), 64'd40);

    // One-cycle reset in the middle of a stream, then resync.
    run_req = 3'b000;
    repeat (2) cycle();
    src[0] = 32'h0000_0100; src[1] = 32'h0000_0100 + radio_init(1, 2, 32);
    phase_w[0] = 0; phase_w[1] = 0; skip_at[0] = 0; skip_at[1] = 0;
    run_req = 3'b011;
    run_until(0, 30);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    chk("mid_rst_stb", 64'(a_if.radio_tx_stb), 64'd0);
    chk("mid_rst_wc",  a_wc, 64'd0);
    chk("mid_rst_ec",  a_ec, 64'd0);
    chk("mid_rst_ft",  a_ft[63:0], 64'd0);
    chk("mid_rst_lk",  64'(a_lk), 64'd0);
    phase_w[0] = 0; phase_w[1] = 0;
    run_until(0, 25);
    chk_chan(0, "resync_c0", 32'd0);
    chk_chan(1, "resync_c1", 32'd0);
    chk("resync_wc", 64'(wc(0)), 64'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
